spi_slave_regfile: RTL and testbench



---
 rtl/spi_slave_regfile.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile
//
// SPI responder for the 3-wire configuration link (CSN / SCK / shared DN).
// The SPI pins are oversampled on ACLK. The block decodes 16-bit frames and
// serves a small register file of 8-bit registers.
//
// Frame format, MSB first:
//   bit 15     R/W (1 = read)
//   bits 14:8  address
//   bits 7:0   data
// The block samples SPI_DI on SCK rise and changes SPI_DO on SCK fall (mode 0).
//
// Parameters
//   NREGS     number of 8-bit registers (2..128); addresses >= NREGS unmapped
//   ID_VALUE  read-only contents of address 0
//
// Ports
//   ACLK       system clock, at least 8x the SCK frequency
//   ARESETn    asynchronous active-low reset
//   SPI_CSN    chip select, active low, asynchronous to ACLK
//   SPI_SCK    SPI clock, idle low, asynchronous to ACLK
//   SPI_DI     data from the master (pad input side of DN)
//   SPI_DO     data to the master (pad output side of DN)
//   SPI_DO_OE  pad output enable; 1 = this block drives DN
//   wr_stb     one-cycle pulse on every committed write
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   regs_flat  register file contents; register n is at [8n+7:8n]
// -----------------------------------------------------------------------------
module spi_slave_regfile #(
    parameter int          NREGS    = 16,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 SPI_CSN,
    input  logic                 SPI_SCK,
    input  logic                 SPI_DI,
    output logic                 SPI_DO,
    output logic                 SPI_DO_OE,
    output logic                 wr_stb,
    output logic [6:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic [8*NREGS-1:0]   regs_flat
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Synchronizers: [0] first flop, [1] synchronized value, [2] edge-detect history
    logic [2:0] csn_sync_q, csn_sync_d;
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [1:0] di_sync_q,  di_sync_d;

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q,   cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             tx_q,    tx_d;
    logic                   rw_q,    rw_d;
    logic [6:0]             addr_q,  addr_d;
    logic                   do_q,    do_d;
    logic                   oe_q,    oe_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [NREGS-1:0][7:0]  regs_q,  regs_d;

    logic       csn_fall_s;
    logic       csn_rise_s;
    logic       sck_rise_s;
    logic       sck_fall_s;
    logic       di_s;
    logic [7:0] shift_nxt_s;
    logic [7:0] rd_val_s;
    logic       addr_ok_s;

    // Next value of each synchronizer chain: shift the pin in at bit 0
    always_comb begin
        csn_sync_d = {csn_sync_q[1:0], SPI_CSN};
        sck_sync_d = {sck_sync_q[1:0], SPI_SCK};
        di_sync_d  = {di_sync_q[0],    SPI_DI};
    end

    assign csn_fall_s  = ~csn_sync_q[1] &  csn_sync_q[2];
    assign csn_rise_s  =  csn_sync_q[1] & ~csn_sync_q[2];
    assign sck_rise_s  =  sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall_s  = ~sck_sync_q[1] &  sck_sync_q[2];
    assign di_s        =  di_sync_q[1];
    assign shift_nxt_s = {shift_q[6:0], di_s};

    // Writes only land on mapped, writable addresses (address 0 is the ID)
    assign addr_ok_s = (addr_q != 7'd0) && ({1'b0, addr_q} < 8'(NREGS));

    // Read-data mux for the address just completed in the command byte;
    // unmapped addresses fall through to 8'h00
    always_comb begin
        rd_val_s = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            rd_val_s = (shift_nxt_s[6:0] == 7'(i)) ? regs_q[i] : rd_val_s;
        end
    end

    // Frame FSM, shifter, read transmitter and register-file write path
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        do_d      = do_q;
        oe_d      = oe_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        regs_d    = regs_q;
        regs_d[0] = ID_VALUE;

        // CSN rise ends the frame from any state and beats a same-cycle SCK edge
        if (csn_rise_s) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            do_d    = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csn_fall_s) begin
                        state_d = ST_CMD;
                        cnt_d   = 4'd0;
                        shift_d = 8'h00;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_CMD: begin
                    if (sck_rise_s) begin
                        shift_d = shift_nxt_s;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rw_d    = shift_nxt_s[7];
                            addr_d  = shift_nxt_s[6:0];
                            tx_d    = shift_nxt_s[7] ? rd_val_s : 8'h00;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end

                ST_DATA: begin
                    // Read data launches on every fall seen in DATA, starting
                    // with the fall that closes the command byte
                    if (sck_fall_s && rw_q) begin
                        do_d = tx_q[7];
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = 1'b1;
                    end else begin
                        do_d = do_q;
                    end

                    if (sck_rise_s) begin
                        shift_d = shift_nxt_s;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_d = ST_HOLD;
                            if (!rw_q && addr_ok_s) begin
                                for (int i = 1; i < NREGS; i++) begin
                                    regs_d[i] = (addr_q == 7'(i)) ? shift_nxt_s : regs_q[i];
                                end
                                wr_stb_d  = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = shift_nxt_s;
                            end else begin
                                wr_stb_d = 1'b0;
                            end
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end

                ST_HOLD: begin
                    state_d = ST_HOLD;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers, asynchronous active-low reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            csn_sync_q <= 3'b111;
            sck_sync_q <= 3'b000;
            di_sync_q  <= 2'b00;
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            addr_q     <= 7'd0;
            do_q       <= 1'b0;
            oe_q       <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 8'h00;
            regs_q     <= {{(NREGS-1){8'h00}}, ID_VALUE};
        end else begin
            csn_sync_q <= csn_sync_d;
            sck_sync_q <= sck_sync_d;
            di_sync_q  <= di_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            do_q       <= do_d;
            oe_q       <= oe_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign SPI_DO    = do_q;
    assign SPI_DO_OE = oe_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign regs_flat = regs_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regfile
//
// Drives SPI frames into spi_slave_regfile and compares read data, output
// enable, write strobes and the register file against a simple array model
// of the register map.
// -----------------------------------------------------------------------------
module tb_spi_slave_regfile;

    localparam int NREGS = 16;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 spi_csn = 1'b1;
    logic                 spi_sck = 1'b0;
    logic                 spi_di  = 1'b0;
    logic                 spi_do;
    logic                 spi_oe;
    logic                 wr_stb;
    logic [6:0]           wr_addr;
    logic [7:0]           wr_data;
    logic [8*NREGS-1:0]   regs_flat;

    spi_slave_regfile #(.NREGS(NREGS), .ID_VALUE(8'hA5)) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .SPI_CSN   (spi_csn),
        .SPI_SCK   (spi_sck),
        .SPI_DI    (spi_di),
        .SPI_DO    (spi_do),
        .SPI_DO_OE (spi_oe),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model of the register map
    logic [7:0] m_regs [NREGS];
    logic [6:0] m_waddr;
    logic [7:0] m_wdata;

    // Strobe monitor: total high cycles and number of pulses
    int   stb_cycles = 0;
    int   stb_pulses = 0;
    logic stb_prev   = 1'b0;

    always @(posedge clk) begin
        if (wr_stb) stb_cycles <= stb_cycles + 1;
        if (wr_stb && !stb_prev) stb_pulses <= stb_pulses + 1;
        stb_prev <= wr_stb;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_waddr = 7'd0;
        m_wdata = 8'h00;
    endtask

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = (i == 0) ? 8'hA5 : m_regs[i];
        return f;
    endfunction

    function automatic logic [7:0] exp_read(input logic [6:0] a);
        if (a == 7'd0) return 8'hA5;
        if (int'(a) >= NREGS) return 8'h00;
        return m_regs[a[3:0]];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "/do_idle"}, 128'(spi_do), 128'd0);
        check({tag, "/oe_idle"}, 128'(spi_oe), 128'd0);
        check({tag, "/regs"}, 128'(regs_flat), m_flat());
        check({tag, "/wr_addr"}, 128'(wr_addr), 128'(m_waddr));
        check({tag, "/wr_data"}, 128'(wr_data), 128'(m_wdata));
    endtask

    // One frame of nbits SCK periods, half = SCK half period in ACLK cycles
    task automatic run_frame(input logic [15:0] w, input int nbits, input int half, input string tag);
        int         c0     = stb_cycles;
        int         p0     = stb_pulses;
        int         oe_bad = 0;
        int         exp_stb = 0;
        logic [7:0] rd     = 8'h00;
        logic       is_rd  = w[15];
        logic [6:0] a      = w[14:8];
        logic       exp_oe;

        @(negedge clk);
        spi_csn = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_di = (i < 16) ? w[15-i] : 1'($urandom);
            repeat (half) @(negedge clk);
            exp_oe = is_rd && (i >= 8);
            if (spi_oe !== exp_oe) oe_bad++;
            if (i >= 8 && i < 16) rd = {rd[6:0], spi_do};
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_csn = 1'b1;
        repeat (6) @(negedge clk);

        if (nbits >= 16 && !is_rd && a != 7'd0 && int'(a) < NREGS) begin
            m_regs[a[3:0]] = w[7:0];
            m_waddr        = a;
            m_wdata        = w[7:0];
            exp_stb        = 1;
        end
        if (nbits >= 16 && is_rd) check({tag, "/rdata"}, 128'(rd), 128'(exp_read(a)));
        check({tag, "/oe_in_frame"}, 128'(oe_bad), 128'd0);
        check({tag, "/stb_cycles"}, 128'(stb_cycles - c0), 128'(exp_stb));
        check({tag, "/stb_pulses"}, 128'(stb_pulses - p0), 128'(exp_stb));
        check_idle_outputs(tag);
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/stb", 128'(wr_stb), 128'd0);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed cases
        run_frame(16'h8000, 16, 8, "id_read");
        run_frame(16'h035C, 16, 8, "wr3");
        run_frame(16'h8300, 16, 8, "rd3");
        run_frame(16'h0099, 16, 8, "wr_addr0");
        run_frame(16'h1077, 16, 8, "wr_addr16");
        run_frame(16'h9000, 16, 8, "rd_addr16");
        run_frame(16'h07FF, 12, 8, "wr7_abort");
        run_frame(16'h0711, 16, 8, "wr7");
        run_frame(16'h8700, 16, 8, "rd7");
        run_frame(16'h0242, 20, 8, "wr2_long");
        run_frame(16'h8242, 20, 5, "rd2_long");

        // Reset in the middle of a read (bit 10)
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi_di = (i == 0);
            repeat (8) @(negedge clk);
            spi_sck = 1'b1;
            repeat (8) @(negedge clk);
            spi_sck = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("midrst/stb", 128'(wr_stb), 128'd0);
        check_idle_outputs("midrst");
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(16'h8000, 16, 4, "post_rst_id");
        run_frame(16'h8300, 16, 4, "post_rst_rd3");

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            logic [15:0] w;
            int          nb;
            int          sel;
            w[15]    = 1'($urandom);
            w[14:8]  = 7'($urandom_range(0, 20));
            w[7:0]   = 8'($urandom);
            sel      = $urandom_range(0, 9);
            if (sel < 7)       nb = 16;
            else if (sel == 7) nb = $urandom_range(1, 15);
            else               nb = $urandom_range(17, 20);
            run_frame(w, nb, $urandom_range(4, 6), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
